// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: a synchroniser chain per input, followed by a stability
// filter that produces a clean level, registered edge pulses and sticky glitch flags.
module sync_filter_bank #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_LEN    = 4,
  parameter logic [N_CH-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N_CH-1:0] in_sig,
  input  logic            filt_bypass,
  input  logic            glitch_clr,
  output logic [N_CH-1:0] out_sig,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] glitch_flag
);

  localparam int             CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;

  // Only sync_q[0] ever samples the raw pins; every later stage sees a clk-domain value.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= RESET_VALUE;
    end else begin
      sync_q[0] <= in_sig;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, fall_q, glitch_q;
    logic          set_glitch;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
      cnt_d      = cnt_q;
      out_d      = out_q;
      set_glitch = 1'b0;
      if (filt_bypass) begin
        cnt_d = '0;
        out_d = s[ch];
      end else if (s[ch] == out_q) begin
        if (cnt_q != '0) begin
          cnt_d      = '0;
          set_glitch = 1'b1;
        end
      end else if (cnt_q == CNT_LAST) begin
        out_d = s[ch];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A coincident set beats glitch_clr so a rejection in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        cnt_q    <= '0;
        out_q    <= RESET_VALUE[ch];
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        rise_q   <= out_d & ~out_q;
        fall_q   <= ~out_d & out_q;
        glitch_q <= (glitch_q & ~glitch_clr) | set_glitch;
      end
    end

    assign out_sig[ch]     = out_q;
    assign rise[ch]        = rise_q;
    assign fall[ch]        = fall_q;
    assign glitch_flag[ch] = glitch_q;
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench for sync_filter_bank: four parameterisations driven in parallel,
// compared every cycle against a sample-history model plus directed latency/flag checks.
module tb_sync_filter_bank;

  localparam int NI = 4;  // 0: RESET_VALUE=0101, 1: defaults, 2: S3/F1, 3: S3/F8
  localparam int         SY [NI] = '{2, 2, 3, 3};
  localparam int         FL [NI] = '{4, 4, 1, 8};
  localparam logic [3:0] RV [NI] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};

  logic       clk, nrst, filt_bypass, glitch_clr;
  logic [3:0] in_sig;
  logic [3:0] out_w [NI];
  logic [3:0] rise_w [NI];
  logic [3:0] fall_w [NI];
  logic [3:0] glitch_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  sync_filter_bank #(.N_CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RESET_VALUE(4'b0101)) u_rv (
    .clk(clk), .nrst(nrst), .in_sig(in_sig), .filt_bypass(filt_bypass), .glitch_clr(glitch_clr),
    .out_sig(out_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .glitch_flag(glitch_w[0]));
  sync_filter_bank #(.N_CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RESET_VALUE(4'b0000)) u_def (
    .clk(clk), .nrst(nrst), .in_sig(in_sig), .filt_bypass(filt_bypass), .glitch_clr(glitch_clr),
    .out_sig(out_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .glitch_flag(glitch_w[1]));
  sync_filter_bank #(.N_CH(4), .SYNC_STAGES(3), .FILT_LEN(1), .RESET_VALUE(4'b0000)) u_s3f1 (
    .clk(clk), .nrst(nrst), .in_sig(in_sig), .filt_bypass(filt_bypass), .glitch_clr(glitch_clr),
    .out_sig(out_w[2]), .rise(rise_w[2]), .fall(fall_w[2]), .glitch_flag(glitch_w[2]));
  sync_filter_bank #(.N_CH(4), .SYNC_STAGES(3), .FILT_LEN(8), .RESET_VALUE(4'b0000)) u_s3f8 (
    .clk(clk), .nrst(nrst), .in_sig(in_sig), .filt_bypass(filt_bypass), .glitch_clr(glitch_clr),
    .out_sig(out_w[3]), .rise(rise_w[3]), .fall(fall_w[3]), .glitch_flag(glitch_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a delay line of raw samples plus, per channel, the length of the current run of
  // synced samples that disagree with the output level.
  logic [3:0] m_hist [NI][4];
  logic [3:0] m_out [NI];
  logic [3:0] m_rise [NI];
  logic [3:0] m_fall [NI];
  logic [3:0] m_gl [NI];
  int         m_run [NI][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 4; j++) begin
        m_hist[i][j] = RV[i];
        m_run[i][j]  = 0;
      end
      m_out[i]  = RV[i];
      m_rise[i] = '0;
      m_fall[i] = '0;
      m_gl[i]   = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic [3:0] smp;
      logic [3:0] nxt;
      logic [3:0] set;
      smp = m_hist[i][SY[i]-1];
      nxt = m_out[i];
      set = '0;
      for (int c = 0; c < 4; c++) begin
        if (filt_bypass) begin
          nxt[c] = smp[c];
          m_run[i][c] = 0;
        end else if (smp[c] != m_out[i][c]) begin
          m_run[i][c]++;
          if (m_run[i][c] >= FL[i]) begin
            nxt[c] = smp[c];
            m_run[i][c] = 0;
          end
        end else begin
          if (m_run[i][c] > 0) set[c] = 1'b1;
          m_run[i][c] = 0;
        end
      end
      m_rise[i] = nxt & ~m_out[i];
      m_fall[i] = ~nxt & m_out[i];
      m_gl[i]   = (m_gl[i] & ~{4{glitch_clr}}) | set;
      m_out[i]  = nxt;
      for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = in_sig;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d_out", i),    32'(out_w[i]),    32'(m_out[i]));
      check($sformatf("u%0d_rise", i),   32'(rise_w[i]),   32'(m_rise[i]));
      check($sformatf("u%0d_fall", i),   32'(fall_w[i]),   32'(m_fall[i]));
      check($sformatf("u%0d_glitch", i), 32'(glitch_w[i]), 32'(m_gl[i]));
    end
  endtask

  // One clock: model advances on the edge, outputs compared at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    bit q2 [$];
    nrst        = 1'b1;
    filt_bypass = 1'b0;
    glitch_clr  = 1'b0;
    in_sig      = 4'($urandom);
    #1 nrst = 1'b0;
    model_reset();

    // Reset values with random inputs, held in reset across several edges
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_sig = 4'($urandom);
      check("rst_out",    32'(out_w[0]),    32'h5);
      check("rst_rise",   32'(rise_w[0]),   32'h0);
      check("rst_fall",   32'(fall_w[0]),   32'h0);
      check("rst_glitch", 32'(glitch_w[0]), 32'h0);
      check_all();
    end
    in_sig = 4'b0000;
    nrst   = 1'b1;
    tick();
    check("rel_out",  32'(out_w[0]),  32'h5);
    check("rel_edge", 32'(rise_w[0] | fall_w[0] | glitch_w[0]), 32'h0);
    settle(14);

    // Clean step on ch0: latency SYNC_STAGES+FILT_LEN per instance
    in_sig = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("step_def_out_e%0d", e),  32'(out_w[1][0]),  32'(e >= 6));
      check($sformatf("step_def_rise_e%0d", e), 32'(rise_w[1]),    (e == 6) ? 32'h1 : 32'h0);
      check($sformatf("step_def_fall_e%0d", e), 32'(fall_w[1]),    32'h0);
      check($sformatf("step_def_gl_e%0d", e),   32'(glitch_w[1]),  32'h0);
      check($sformatf("step_f1_out_e%0d", e),   32'(out_w[2][0]),  32'(e >= 4));
      check($sformatf("step_f1_rise_e%0d", e),  32'(rise_w[2][0]), 32'(e == 4));
      check($sformatf("step_f8_out_e%0d", e),   32'(out_w[3][0]),  32'(e >= 11));
      check($sformatf("step_f8_rise_e%0d", e),  32'(rise_w[3][0]), 32'(e == 11));
    end
    settle(8);

    // Short pulse on ch1: rejected, flagged, then cleared
    in_sig = 4'b0011;
    settle(3);
    in_sig = 4'b0001;
    settle(8);
    check("pulse_out",  32'(out_w[1][1]),    32'h0);
    check("pulse_gl",   32'(glitch_w[1][1]), 32'h1);
    check("pulse_f1",   32'(glitch_w[2][1]), 32'h0);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    check("clr_gl", 32'(glitch_w[1]), 32'h0);

    // Same pulse with glitch_clr coinciding with the set edge (edge 6 for defaults)
    in_sig = 4'b0011;
    settle(3);
    in_sig = 4'b0001;
    settle(2);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    check("coinc_gl", 32'(glitch_w[1][1]), 32'h1);
    settle(4);
    check("coinc_hold", 32'(glitch_w[1][1]), 32'h1);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;

    // Bypass: ch2 toggles every 2 cycles, out follows after SYNC_STAGES+1 edges
    filt_bypass = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t % 2 == 0) in_sig[2] = ~in_sig[2];
      q2.push_back(in_sig[2]);
      tick();
      if (q2.size() >= 3) check($sformatf("byp_out_t%0d", t), 32'(out_w[1][2]), 32'(q2[q2.size()-3]));
      check($sformatf("byp_gl_t%0d", t), 32'(glitch_w[1][2]), 32'h0);
    end
    settle(4);
    filt_bypass = 1'b0;
    settle(10);

    // Simultaneous: ch0 rises while ch3 falls
    in_sig = 4'b1000;
    settle(15);
    in_sig = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("sim_out_e%0d", e),  32'(out_w[1]),  (e >= 6) ? 32'h1 : 32'h8);
      check($sformatf("sim_rise_e%0d", e), 32'(rise_w[1]), (e == 6) ? 32'h1 : 32'h0);
      check($sformatf("sim_fall_e%0d", e), 32'(fall_w[1]), (e == 6) ? 32'h8 : 32'h0);
    end
    settle(6);

    // Reset asserted with ch0 mid-count (cnt=2 after edge 4)
    in_sig = 4'b0000;
    settle(4);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    check("midrst_out",   32'(out_w[1]),    32'h0);
    check("midrst_rv",    32'(out_w[0]),    32'h5);
    check("midrst_pulse", 32'(rise_w[1] | fall_w[1]), 32'h0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    settle(12);

    // Randomised phase: sparse input flips, occasional clear / bypass changes
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) in_sig[c] = ~in_sig[c];
      glitch_clr = ($urandom_range(15) == 0);
      if ($urandom_range(39) == 0) filt_bypass = ~filt_bypass;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
